// File: rtl/ddr_cmd_sequencer_pkg.sv
// ddr_cmd_sequencer_pkg: shared DDR command enum, address widths, default timings and sequencer states.
package ddr_cmd_sequencer_pkg;
    localparam int BG_WIDTH   = 2;
    localparam int BA_WIDTH   = 2;
    localparam int ROW_WIDTH  = 15;
    localparam int COL_WIDTH  = 10;
    localparam int DATA_WIDTH = 64;
    localparam int T_RCD_DEF  = 4;
    localparam int T_RAS_DEF  = 10;
    localparam int T_RTP_DEF  = 2;
    localparam int T_WRP_DEF  = 8;
    localparam int T_RP_DEF   = 4;
    localparam int T_RFC_DEF  = 20;
    localparam int T_REFI_DEF = 100;
    typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_CAS_R, CMD_CAS_W, CMD_PRE, CMD_REF} ddr_cmd_e;
    typedef enum logic [3:0] {
        S_IDLE, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_PRE, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC
    } seq_state_e;
    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/ddr_cmd_sequencer_refresh_timer.sv
// ddr_refresh_timer: free-running refresh interval counter raising a sticky refresh request.
module ddr_refresh_timer #(
    parameter int T_REFI = 100
) (
    input  logic clock_t,
    input  logic reset,
    input  logic ref_ack,
    output logic ref_pending
);
    localparam int CW = $clog2(T_REFI + 1);
    localparam logic [CW-1:0] LAST = CW'(T_REFI - 1);
    logic [CW-1:0] cnt_q;
    logic          pend_q;
    logic          wrap;
    assign wrap = cnt_q == LAST;
    // A wrap on the same edge as an ack starts a fresh interval, so set wins.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= wrap ? '0 : cnt_q + CW'(1);
            pend_q <= wrap | (pend_q & ~ref_ack);
        end
    end
    assign ref_pending = pend_q;
endmodule

// File: rtl/ddr_cmd_sequencer.sv
// ddr_cmd_sequencer: closed-page single-request DDR command sequencer (ACT, CAS, PRE) with periodic refresh.
module ddr_cmd_sequencer
    import ddr_cmd_sequencer_pkg::*;
#(
    parameter int T_RCD  = T_RCD_DEF,
    parameter int T_RAS  = T_RAS_DEF,
    parameter int T_RTP  = T_RTP_DEF,
    parameter int T_WRP  = T_WRP_DEF,
    parameter int T_RP   = T_RP_DEF,
    parameter int T_RFC  = T_RFC_DEF,
    parameter int T_REFI = T_REFI_DEF
) (
    input  logic                  clock_t,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [BG_WIDTH-1:0]   req_bg,
    input  logic [BA_WIDTH-1:0]   req_ba,
    input  logic [ROW_WIDTH-1:0]  req_row,
    input  logic [COL_WIDTH-1:0]  req_col,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  cmd_valid,
    output ddr_cmd_e              cmd,
    output logic [BG_WIDTH-1:0]   cmd_bg,
    output logic [BA_WIDTH-1:0]   cmd_ba,
    output logic [ROW_WIDTH-1:0]  cmd_row,
    output logic [COL_WIDTH-1:0]  cmd_col,
    output logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  busy
);
    localparam int T_MAX = imax(imax(imax(T_RCD, T_RAS), imax(T_RTP, T_WRP)), imax(T_RP, T_RFC));
    localparam int CW    = $clog2(T_MAX + 1);
    // Idle cycles spent in each wait state; PRE lands at ACT + max(T_RAS, T_RCD + recovery).
    localparam int RCD_W = T_RCD - 1;
    localparam int PRE_R = imax(T_RAS - T_RCD, T_RTP) - 1;
    localparam int PRE_W = imax(T_RAS - T_RCD, T_WRP) - 1;
    localparam int RP_W  = imax(T_RP - 2, 0);
    localparam int RFC_W = imax(T_RFC - 2, 0);

    seq_state_e            state_q;
    logic [CW-1:0]         cnt_q;
    logic                  wr_q;
    logic [BG_WIDTH-1:0]   bg_q;
    logic [BA_WIDTH-1:0]   ba_q;
    logic [ROW_WIDTH-1:0]  row_q;
    logic [COL_WIDTH-1:0]  col_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  cmd_valid_q;
    ddr_cmd_e              cmd_q;
    logic [BG_WIDTH-1:0]   cmd_bg_q;
    logic [BA_WIDTH-1:0]   cmd_ba_q;
    logic [ROW_WIDTH-1:0]  cmd_row_q;
    logic [COL_WIDTH-1:0]  cmd_col_q;
    logic [DATA_WIDTH-1:0] cmd_wdata_q;
    logic                  ref_pending;
    logic                  ref_ack;
    logic                  pre_now;

    assign ref_ack   = (state_q == S_IDLE) & ref_pending;
    assign req_ready = (state_q == S_IDLE) & ~ref_pending & ~reset;
    assign busy      = state_q != S_IDLE;
    assign pre_now   = wr_q ? (PRE_W == 0) : (PRE_R == 0);

    ddr_refresh_timer #(.T_REFI(T_REFI)) u_refresh (
        .clock_t    (clock_t),
        .reset      (reset),
        .ref_ack    (ref_ack),
        .ref_pending(ref_pending)
    );

    always_ff @(posedge clock_t) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            bg_q        <= '0;
            ba_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            wdata_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            cmd_bg_q    <= '0;
            cmd_ba_q    <= '0;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            cmd_wdata_q <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            case (state_q)
                S_IDLE: begin
                    if (ref_pending) begin
                        state_q     <= S_REF;
                        cmd_valid_q <= 1'b1;
                        cmd_q       <= CMD_REF;
                    end else if (req_valid) begin
                        state_q     <= S_ACT;
                        wr_q        <= req_write;
                        bg_q        <= req_bg;
                        ba_q        <= req_ba;
                        row_q       <= req_row;
                        col_q       <= req_col;
                        wdata_q     <= req_wdata;
                        cmd_valid_q <= 1'b1;
                        cmd_q       <= CMD_ACT;
                        cmd_bg_q    <= req_bg;
                        cmd_ba_q    <= req_ba;
                        cmd_row_q   <= req_row;
                    end
                end
                S_ACT, S_WAIT_RCD: begin
                    if ((state_q == S_ACT && RCD_W == 0) || (state_q == S_WAIT_RCD && cnt_q == '0)) begin
                        state_q     <= S_CAS;
                        cmd_valid_q <= 1'b1;
                        cmd_q       <= wr_q ? CMD_CAS_W : CMD_CAS_R;
                        cmd_bg_q    <= bg_q;
                        cmd_ba_q    <= ba_q;
                        cmd_col_q   <= col_q;
                        cmd_wdata_q <= wr_q ? wdata_q : cmd_wdata_q;
                    end else if (state_q == S_ACT) begin
                        state_q <= S_WAIT_RCD;
                        cnt_q   <= CW'(RCD_W - 1);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_CAS, S_WAIT_PRE: begin
                    if ((state_q == S_CAS && pre_now) || (state_q == S_WAIT_PRE && cnt_q == '0)) begin
                        state_q     <= S_PRE;
                        cmd_valid_q <= 1'b1;
                        cmd_q       <= CMD_PRE;
                        cmd_bg_q    <= bg_q;
                        cmd_ba_q    <= ba_q;
                    end else if (state_q == S_CAS) begin
                        state_q <= S_WAIT_PRE;
                        cnt_q   <= wr_q ? CW'(PRE_W - 1) : CW'(PRE_R - 1);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_PRE: begin
                    state_q <= (RP_W == 0) ? S_IDLE : S_WAIT_RP;
                    cnt_q   <= CW'(RP_W - 1);
                end
                S_REF: begin
                    state_q <= (RFC_W == 0) ? S_IDLE : S_WAIT_RFC;
                    cnt_q   <= CW'(RFC_W - 1);
                end
                S_WAIT_RP, S_WAIT_RFC: begin
                    state_q <= (cnt_q == '0) ? S_IDLE : state_q;
                    cnt_q   <= cnt_q - CW'(1);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign cmd_bg    = cmd_bg_q;
    assign cmd_ba    = cmd_ba_q;
    assign cmd_row   = cmd_row_q;
    assign cmd_col   = cmd_col_q;
    assign cmd_wdata = cmd_wdata_q;
endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// tb_ddr_cmd_sequencer: event-time reference model of the sequencer checked every cycle on two parameter sets.
module tb_ddr_cmd_sequencer;
    import ddr_cmd_sequencer_pkg::*;
    localparam int NI = 2;

    int p_rcd[NI]  = '{4, 1};
    int p_ras[NI]  = '{10, 2};
    int p_rtp[NI]  = '{2, 1};
    int p_wrp[NI]  = '{8, 8};
    int p_rp[NI]   = '{4, 1};
    int p_rfc[NI]  = '{20, 20};
    int p_refi[NI] = '{100, 100};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset, req_valid, req_write;
    logic [BG_WIDTH-1:0]   req_bg;
    logic [BA_WIDTH-1:0]   req_ba;
    logic [ROW_WIDTH-1:0]  req_row;
    logic [COL_WIDTH-1:0]  req_col;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready[NI], cmd_valid[NI], busy[NI];
    ddr_cmd_e              cmd[NI];
    logic [BG_WIDTH-1:0]   cmd_bg[NI];
    logic [BA_WIDTH-1:0]   cmd_ba[NI];
    logic [ROW_WIDTH-1:0]  cmd_row[NI];
    logic [COL_WIDTH-1:0]  cmd_col[NI];
    logic [DATA_WIDTH-1:0] cmd_wdata[NI];

    ddr_cmd_sequencer u0 (
        .clock_t(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
        .req_ready(req_ready[0]), .cmd_valid(cmd_valid[0]), .cmd(cmd[0]), .cmd_bg(cmd_bg[0]),
        .cmd_ba(cmd_ba[0]), .cmd_row(cmd_row[0]), .cmd_col(cmd_col[0]), .cmd_wdata(cmd_wdata[0]), .busy(busy[0])
    );

    ddr_cmd_sequencer #(.T_RCD(1), .T_RAS(2), .T_RTP(1), .T_RP(1)) u1 (
        .clock_t(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
        .req_ready(req_ready[1]), .cmd_valid(cmd_valid[1]), .cmd(cmd[1]), .cmd_bg(cmd_bg[1]),
        .cmd_ba(cmd_ba[1]), .cmd_row(cmd_row[1]), .cmd_col(cmd_col[1]), .cmd_wdata(cmd_wdata[1]), .busy(busy[1])
    );

    int n_checks, n_fail, cyc;
    int idle_at[NI], act_t[NI], cas_t[NI], pre_t[NI], ref_t[NI];
    bit pend[NI], ack[NI], m_wr[NI];
    logic [BG_WIDTH-1:0]   m_bg[NI], e_bg[NI];
    logic [BA_WIDTH-1:0]   m_ba[NI], e_ba[NI];
    logic [ROW_WIDTH-1:0]  m_row[NI], e_row[NI];
    logic [COL_WIDTH-1:0]  m_col[NI], e_col[NI];
    logic [DATA_WIDTH-1:0] m_wd[NI], e_wd[NI];
    ddr_cmd_e              log_cmd[NI][256];
    logic                  log_ready[NI][256];
    logic [DATA_WIDTH-1:0] log_wd[NI][256];

    function automatic int imx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input int i, input string nm, input logic [63:0] a, input logic [63:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, i, cyc, a, e);
        end
    endtask

    task automatic model_init();
        cyc = 0;
        for (int i = 0; i < NI; i++) begin
            idle_at[i] = 0; act_t[i] = -1; cas_t[i] = -1; pre_t[i] = -1; ref_t[i] = -1;
            pend[i] = 0; ack[i] = 0;
            e_bg[i] = '0; e_ba[i] = '0; e_row[i] = '0; e_col[i] = '0; e_wd[i] = '0;
        end
    endtask

    task automatic check_cycle();
        for (int i = 0; i < NI; i++) begin
            bit idle;
            ddr_cmd_e ec;
            if (ack[i]) pend[i] = 0;
            ack[i] = 0;
            if (cyc > 0 && cyc % p_refi[i] == 0) pend[i] = 1;
            idle = cyc >= idle_at[i];
            ec = CMD_NOP;
            if (cyc == act_t[i]) begin
                ec = CMD_ACT; e_bg[i] = m_bg[i]; e_ba[i] = m_ba[i]; e_row[i] = m_row[i];
            end else if (cyc == cas_t[i]) begin
                ec = m_wr[i] ? CMD_CAS_W : CMD_CAS_R; e_bg[i] = m_bg[i]; e_ba[i] = m_ba[i]; e_col[i] = m_col[i];
                if (m_wr[i]) e_wd[i] = m_wd[i];
            end else if (cyc == pre_t[i]) begin
                ec = CMD_PRE; e_bg[i] = m_bg[i]; e_ba[i] = m_ba[i];
            end else if (cyc == ref_t[i]) begin
                ec = CMD_REF;
            end
            chk(i, "cmd_valid", cmd_valid[i], ec != CMD_NOP);
            chk(i, "cmd", cmd[i], ec);
            chk(i, "req_ready", req_ready[i], idle && !pend[i]);
            chk(i, "busy", busy[i], !idle);
            chk(i, "cmd_bg", cmd_bg[i], e_bg[i]);
            chk(i, "cmd_ba", cmd_ba[i], e_ba[i]);
            chk(i, "cmd_row", cmd_row[i], e_row[i]);
            chk(i, "cmd_col", cmd_col[i], e_col[i]);
            chk(i, "cmd_wdata", cmd_wdata[i], e_wd[i]);
            if (cyc < 256) begin
                log_cmd[i][cyc] = cmd[i]; log_ready[i][cyc] = req_ready[i]; log_wd[i][cyc] = cmd_wdata[i];
            end
            if (idle && pend[i]) begin
                ref_t[i] = cyc + 1;
                idle_at[i] = cyc + 1 + imx(p_rfc[i] - 1, 1);
                ack[i] = 1;
            end else if (idle && req_valid) begin
                m_wr[i] = req_write; m_bg[i] = req_bg; m_ba[i] = req_ba;
                m_row[i] = req_row; m_col[i] = req_col; m_wd[i] = req_wdata;
                act_t[i] = cyc + 1;
                cas_t[i] = act_t[i] + p_rcd[i];
                pre_t[i] = act_t[i] + imx(p_ras[i], p_rcd[i] + (req_write ? p_wrp[i] : p_rtp[i]));
                idle_at[i] = pre_t[i] + imx(p_rp[i] - 1, 1);
            end
        end
    endtask

    task automatic reset_dut(input int n);
        reset = 1'b1;
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                chk(i, "rst_valid", cmd_valid[i], 0);
                chk(i, "rst_cmd", cmd[i], CMD_NOP);
                chk(i, "rst_busy", busy[i], 0);
                chk(i, "rst_ready", req_ready[i], 0);
                chk(i, "rst_addr", {cmd_bg[i], cmd_ba[i], cmd_row[i], cmd_col[i]}, 0);
                chk(i, "rst_wdata", cmd_wdata[i], 0);
            end
        end
        reset = 1'b0;
        model_init();
    endtask

    task automatic step(input logic v, input logic w, input logic [BG_WIDTH-1:0] bg, input logic [BA_WIDTH-1:0] ba,
                        input logic [ROW_WIDTH-1:0] row, input logic [COL_WIDTH-1:0] col, input logic [DATA_WIDTH-1:0] wd);
        req_valid = v; req_write = w; req_bg = bg; req_ba = ba; req_row = row; req_col = col; req_wdata = wd;
        #1;
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rstep(input int pv);
        step($urandom_range(99) < pv, 1'($urandom_range(1)), BG_WIDTH'($urandom), BA_WIDTH'($urandom),
             ROW_WIDTH'($urandom), COL_WIDTH'($urandom), {$urandom, $urandom});
    endtask

    task automatic idle_steps(input int n);
        repeat (n) rstep(0);
    endtask

    int pv_tab[4] = '{30, 100, 0, 60};

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_bg = '0; req_ba = '0;
        req_row = '0; req_col = '0; req_wdata = '0;
        // single read
        reset_dut(2);
        step(1, 0, 2'd1, 2'd2, 15'h1234, 10'h55, 64'h0);
        idle_steps(20);
        chk(0, "lit_rd_act1", log_cmd[0][1], CMD_ACT);
        chk(0, "lit_rd_cas5", log_cmd[0][5], CMD_CAS_R);
        chk(0, "lit_rd_pre11", log_cmd[0][11], CMD_PRE);
        chk(0, "lit_rd_rdy13", log_ready[0][13], 0);
        chk(0, "lit_rd_rdy14", log_ready[0][14], 1);
        chk(1, "lit_fast_cas2", log_cmd[1][2], CMD_CAS_R);
        chk(1, "lit_fast_pre3", log_cmd[1][3], CMD_PRE);
        // single write
        reset_dut(1);
        step(1, 1, 2'd3, 2'd1, 15'h7abc, 10'h3ff, 64'hdeadbeef_12345678);
        idle_steps(20);
        chk(0, "lit_wr_cas5", log_cmd[0][5], CMD_CAS_W);
        chk(0, "lit_wr_wdata5", log_wd[0][5], 64'hdeadbeef_12345678);
        chk(0, "lit_wr_pre13", log_cmd[0][13], CMD_PRE);
        chk(0, "lit_wr_rdy15", log_ready[0][15], 0);
        chk(0, "lit_wr_rdy16", log_ready[0][16], 1);
        chk(1, "lit_fast_wr_pre10", log_cmd[1][10], CMD_PRE);
        // three back-to-back reads
        reset_dut(1);
        for (int k = 0; k < 29; k++) step(1, 0, 2'd0, 2'd3, ROW_WIDTH'(k), 10'h12, 64'h0);
        idle_steps(15);
        chk(0, "lit_b2b_act15", log_cmd[0][15], CMD_ACT);
        chk(0, "lit_b2b_act29", log_cmd[0][29], CMD_ACT);
        chk(0, "lit_b2b_rdy28", log_ready[0][28], 1);
        // refresh wins against a pending request
        reset_dut(1);
        idle_steps(100);
        for (int k = 0; k < 25; k++) step(1, 0, 2'd2, 2'd2, 15'h4242, 10'h21, 64'h0);
        idle_steps(5);
        chk(0, "lit_ref_rdy100", log_ready[0][100], 0);
        chk(0, "lit_ref101", log_cmd[0][101], CMD_REF);
        chk(0, "lit_ref_rdy119", log_ready[0][119], 0);
        chk(0, "lit_ref_rdy120", log_ready[0][120], 1);
        chk(0, "lit_ref_act121", log_cmd[0][121], CMD_ACT);
        // reset the cycle after ACT abandons the access
        reset_dut(1);
        step(1, 1, 2'd1, 2'd1, 15'h0f0f, 10'h0aa, 64'h1111_2222_3333_4444);
        step(0, 0, 2'd0, 2'd0, 15'h0, 10'h0, 64'h0);
        reset_dut(1);
        idle_steps(20);
        chk(0, "lit_post_rst_rdy0", log_ready[0][0], 1);
        // randomized traffic
        reset_dut(1);
        for (int k = 0; k < 4000; k++) rstep(pv_tab[k / 1000]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
